// File: rtl/rename_regfile_pkg.sv
// Shared widths and types for the rename register file.
// Optional busy counter is enabled with macro REGFILE_BUSY_CNT_EN.
package rename_regfile_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_NUM = 32;
  localparam int DEF_REG_W   = 5;
  localparam int DEF_ROB_W   = 4;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_REG_W-1:0]  reg_idx_t;
  typedef logic [DEF_ROB_W-1:0]  rob_tag_t;

endpackage

// File: rtl/regfile_read_port.sv
// One rename read port: x0 handling plus same-cycle commit bypass.
module regfile_read_port
  import rename_regfile_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REG_W        = DEF_REG_W,
  parameter int ROB_W        = DEF_ROB_W,
  parameter int COMMIT_PORTS = 2
) (
  input  logic                           rdy_in,
  input  logic [REG_W-1:0]               idx,
  input  logic [DATA_W-1:0]              st_val,
  input  logic                           st_busy,
  input  logic [ROB_W-1:0]               st_tag,
  input  logic [COMMIT_PORTS-1:0]        cm_valid,
  input  logic [COMMIT_PORTS*REG_W-1:0]  cm_rd,
  input  logic [COMMIT_PORTS*ROB_W-1:0]  cm_tag,
  input  logic [COMMIT_PORTS*DATA_W-1:0] cm_val,
  output logic [DATA_W-1:0]              val,
  output logic                           busy,
  output logic [ROB_W-1:0]               tag
);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    val  = st_val;
    busy = st_busy;
    tag  = st_busy ? st_tag : '0;
    // Ascending scan: the youngest matching commit port is applied last and wins.
    for (int k = 0; k < COMMIT_PORTS; k++) begin
      if (rdy_in && cm_valid[k] && st_busy &&
          cm_tag[k*ROB_W +: ROB_W] == st_tag &&
          cm_rd[k*REG_W +: REG_W] == idx) begin
        val  = cm_val[k*DATA_W +: DATA_W];
        busy = 1'b0;
        tag  = '0;
      end
    end
    if (idx == '0) begin
      val  = '0;
      busy = 1'b0;
      tag  = '0;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy bit and ROB tag.
// Define REGFILE_BUSY_CNT_EN to get a registered popcount of busy bits on busy_cnt.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REG_NUM      = DEF_REG_NUM,
  parameter int REG_W        = DEF_REG_W,
  parameter int ROB_W        = DEF_ROB_W,
  parameter int READ_PORTS   = 2,
  parameter int COMMIT_PORTS = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           issue_valid,
  input  logic [REG_W-1:0]               issue_rd,
  input  logic [ROB_W-1:0]               issue_tag,
  input  logic [READ_PORTS*REG_W-1:0]    rd_idx,
  output logic [READ_PORTS*DATA_W-1:0]   rd_val,
  output logic [READ_PORTS-1:0]          rd_busy,
  output logic [READ_PORTS*ROB_W-1:0]    rd_tag,
  input  logic [COMMIT_PORTS-1:0]        cm_valid,
  input  logic [COMMIT_PORTS*REG_W-1:0]  cm_rd,
  input  logic [COMMIT_PORTS*ROB_W-1:0]  cm_tag,
  input  logic [COMMIT_PORTS*DATA_W-1:0] cm_val,
  input  logic                           flush,
  output logic [REG_W:0]                 busy_cnt
);

  logic [DATA_W-1:0]  val_q   [REG_NUM];
  logic [ROB_W-1:0]   tag_q   [REG_NUM];
  logic [ROB_W-1:0]   tag_nxt [REG_NUM];
  logic [REG_NUM-1:0] busy_q, busy_nxt;

  logic [REG_W-1:0]  cm_rd_a  [COMMIT_PORTS];
  logic [ROB_W-1:0]  cm_tag_a [COMMIT_PORTS];
  logic [DATA_W-1:0] cm_val_a [COMMIT_PORTS];

  for (genvar k = 0; k < COMMIT_PORTS; k++) begin : g_cm
    assign cm_rd_a[k]  = cm_rd[k*REG_W +: REG_W];
    assign cm_tag_a[k] = cm_tag[k*ROB_W +: ROB_W];
    assign cm_val_a[k] = cm_val[k*DATA_W +: DATA_W];
  end

  // Rename state next-value: commit clears, then issue sets, then flush wipes all.
  always_comb begin
    busy_nxt = busy_q;
    tag_nxt  = tag_q;
    for (int k = 0; k < COMMIT_PORTS; k++) begin
      if (cm_valid[k] && cm_rd_a[k] != '0 &&
          busy_q[cm_rd_a[k]] && tag_q[cm_rd_a[k]] == cm_tag_a[k])
        busy_nxt[cm_rd_a[k]] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      busy_nxt[issue_rd] = 1'b1;
      tag_nxt[issue_rd]  = issue_tag;
    end
    if (flush) begin
      busy_nxt = '0;
      for (int i = 0; i < REG_NUM; i++) tag_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: the value array is reset deliberately; reads of never-written registers must return 0, so it cannot map to a reset-less RAM.
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (rdy_in) begin
      // NOTE: non-blocking writes; with several ports on one register the last (youngest) assignment takes effect.
      for (int k = 0; k < COMMIT_PORTS; k++) begin
        if (cm_valid[k] && cm_rd_a[k] != '0) val_q[cm_rd_a[k]] <= cm_val_a[k];
      end
      busy_q <= busy_nxt;
      tag_q  <= tag_nxt;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [REG_W-1:0] idx;
    assign idx = rd_idx[p*REG_W +: REG_W];

    regfile_read_port #(
      .DATA_W       (DATA_W),
      .REG_W        (REG_W),
      .ROB_W        (ROB_W),
      .COMMIT_PORTS (COMMIT_PORTS)
    ) u_port (
      .rdy_in   (rdy_in),
      .idx      (idx),
      .st_val   (val_q[idx]),
      .st_busy  (busy_q[idx]),
      .st_tag   (tag_q[idx]),
      .cm_valid (cm_valid),
      .cm_rd    (cm_rd),
      .cm_tag   (cm_tag),
      .cm_val   (cm_val),
      .val      (rd_val[p*DATA_W +: DATA_W]),
      .busy     (rd_busy[p]),
      .tag      (rd_tag[p*ROB_W +: ROB_W])
    );
  end

`ifdef REGFILE_BUSY_CNT_EN
  logic [REG_W:0] busy_cnt_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     busy_cnt_q <= '0;
    else if (rdy_in) busy_cnt_q <= (REG_W+1)'($countones(busy_nxt));
  end

  assign busy_cnt = busy_cnt_q;
`else
  assign busy_cnt = '0;
`endif

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios plus randomized traffic
// compared against an array-based model of the register file.
module tb_rename_regfile;
  import rename_regfile_pkg::*;

  localparam int DW = 32, NR = 32, RW = 5, TW = 4, RP = 2, CP = 2;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, issue_valid, flush;
  logic [RW-1:0]     issue_rd;
  logic [TW-1:0]     issue_tag;
  logic [RP*RW-1:0]  rd_idx;
  logic [RP*DW-1:0]  rd_val;
  logic [RP-1:0]     rd_busy;
  logic [RP*TW-1:0]  rd_tag;
  logic [CP-1:0]     cm_valid;
  logic [CP*RW-1:0]  cm_rd;
  logic [CP*TW-1:0]  cm_tag;
  logic [CP*DW-1:0]  cm_val;
  logic [RW:0]       busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the architectural state.
  data_t    m_val  [NR];
  bit       m_busy [NR];
  rob_tag_t m_tag  [NR];

  always #5 clk_in = ~clk_in;

  rename_regfile #(
    .DATA_W(DW), .REG_NUM(NR), .REG_W(RW), .ROB_W(TW),
    .READ_PORTS(RP), .COMMIT_PORTS(CP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rd_idx(rd_idx), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endfunction

  // What read port p should show right now, from the rules for reads.
  function automatic void model_read(input int p, output data_t v, output logic b, output rob_tag_t t);
    reg_idx_t r;
    r = rd_idx[p*RW +: RW];
    v = '0; b = 1'b0; t = '0;
    if (r == 0) return;
    v = m_val[r]; b = m_busy[r]; t = m_busy[r] ? m_tag[r] : '0;
    if (!rdy_in || !m_busy[r]) return;
    for (int k = CP - 1; k >= 0; k--) begin
      if (cm_valid[k] && cm_rd[k*RW +: RW] == r && cm_tag[k*TW +: TW] == m_tag[r]) begin
        v = cm_val[k*DW +: DW]; b = 1'b0; t = '0;
        return;
      end
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_next();
    bit       nb [NR];
    rob_tag_t nt [NR];
    reg_idx_t r;
    if (!rdy_in) return;
    nb = m_busy; nt = m_tag;
    for (int k = 0; k < CP; k++) begin
      r = cm_rd[k*RW +: RW];
      if (cm_valid[k] && r != 0) begin
        m_val[r] = cm_val[k*DW +: DW];
        if (m_busy[r] && m_tag[r] == cm_tag[k*TW +: TW]) nb[r] = 1'b0;
      end
    end
    if (issue_valid && issue_rd != 0) begin
      nb[issue_rd] = 1'b1; nt[issue_rd] = issue_tag;
    end
    if (flush) begin
      for (int i = 0; i < NR; i++) begin nb[i] = 1'b0; nt[i] = '0; end
    end
    m_busy = nb; m_tag = nt;
  endfunction

  function automatic logic [RW:0] model_cnt();
    int c;
    c = 0;
`ifdef REGFILE_BUSY_CNT_EN
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
`endif
    return (RW+1)'(c);
  endfunction

  task automatic idle();
    rdy_in = 1'b1; flush = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    cm_valid = '0; cm_rd = '0; cm_tag = '0; cm_val = '0;
  endtask

  task automatic set_rd(input int p, input reg_idx_t r);
    rd_idx[p*RW +: RW] = r;
  endtask

  task automatic set_cm(input int k, input reg_idx_t r, input rob_tag_t t, input data_t v);
    cm_valid[k] = 1'b1;
    cm_rd[k*RW +: RW] = r; cm_tag[k*TW +: TW] = t; cm_val[k*DW +: DW] = v;
  endtask

  task automatic set_issue(input reg_idx_t r, input rob_tag_t t);
    issue_valid = 1'b1; issue_rd = r; issue_tag = t;
  endtask

  task automatic tick();
    model_next();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    idle(); rd_idx = '0; rst_in = 1'b0;
    model_reset();
    #12 rst_in = 1'b1;
    @(posedge clk_in); #1;
    set_rd(0, 5); set_rd(1, 5); #1;
    for (int p = 0; p < RP; p++) begin
      n_vec++;
      if (rd_val[p*DW +: DW] !== 32'h0 || rd_busy[p] !== 1'b0 || rd_tag[p*TW +: TW] !== 4'h0) begin
        n_err++;
        $display("FAIL reset_read p%0d: got val=%h busy=%b tag=%h want 0/0/0",
                 p, rd_val[p*DW +: DW], rd_busy[p], rd_tag[p*TW +: TW]);
      end
    end
    n_vec++;
    if (busy_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_bypass();
    idle(); set_issue(3, 0); tick();
    idle(); set_rd(0, 3); set_rd(1, 3); #1;
    n_vec++;
    if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'h0) begin
      n_err++; $display("FAIL bypass_pending: got busy=%b tag=%h want 1/0", rd_busy[0], rd_tag[3:0]);
    end
    set_cm(0, 3, 0, 32'hDEAD); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'hDEAD || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL bypass_hit: got val=%h busy=%b want dead/0", rd_val[31:0], rd_busy[0]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (rd_val[63:32] !== 32'hDEAD || rd_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL bypass_stored: got val=%h busy=%b want dead/0", rd_val[63:32], rd_busy[1]);
    end
  endtask

  task automatic test_stale_commit();
    idle(); set_issue(7, 2); tick();
    idle(); set_issue(7, 5); tick();
    idle(); set_cm(0, 7, 2, 32'd11); tick();
    idle(); set_rd(0, 7); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'd11 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'h5) begin
      n_err++; $display("FAIL stale_commit: got val=%0d busy=%b tag=%h want 11/1/5",
                        rd_val[31:0], rd_busy[0], rd_tag[3:0]);
    end
  endtask

  task automatic test_multi_commit();
    idle(); set_issue(4, 6); tick();
    idle(); set_rd(0, 4); set_cm(0, 4, 1, 32'd1); set_cm(1, 4, 6, 32'd2); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'd2 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL multi_bypass: got val=%0d busy=%b want 2/0", rd_val[31:0], rd_busy[0]);
    end
    tick(); idle(); #1;
    n_vec++;
    if (rd_val[31:0] !== 32'd2 || rd_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL multi_stored: got val=%0d busy=%b want 2/0", rd_val[31:0], rd_busy[0]);
    end
  endtask

  task automatic test_flush();
    idle(); set_issue(1, 1); tick();
    idle(); set_issue(2, 3); tick();
    idle(); set_issue(9, 7); tick();
    idle(); #1;
    n_vec++;
    if (busy_cnt !== model_cnt()) begin
      n_err++; $display("FAIL flush_precnt: got %0d want %0d", busy_cnt, model_cnt());
    end
    flush = 1'b1; set_issue(10, 4); set_cm(0, 2, 9, 32'h55); tick();
    idle(); set_rd(0, 10); set_rd(1, 2); #1;
    n_vec++;
    if (rd_busy !== 2'b00 || rd_val[63:32] !== 32'h55) begin
      n_err++; $display("FAIL flush_state: got busy=%b val2=%h want 00/55", rd_busy, rd_val[63:32]);
    end
    n_vec++;
    if (busy_cnt !== '0) begin n_err++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_rdy_and_x0();
    idle(); set_issue(12, 3); tick();
    idle(); rdy_in = 1'b0; set_cm(0, 12, 3, 32'd99); set_issue(13, 1);
    set_rd(0, 12); set_rd(1, 13); #1;
    n_vec++;
    if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'h3 || rd_val[31:0] !== 32'd0) begin
      n_err++; $display("FAIL rdy_nobypass: got val=%0d busy=%b tag=%h want 0/1/3",
                        rd_val[31:0], rd_busy[0], rd_tag[3:0]);
    end
    tick(); tick(); #1;
    n_vec++;
    if (rd_busy !== 2'b01 || rd_val[31:0] !== 32'd0) begin
      n_err++; $display("FAIL rdy_frozen: got busy=%b val=%0d want 01/0", rd_busy, rd_val[31:0]);
    end
    idle(); tick(); #1;
    n_vec++;
    if (rd_busy !== 2'b01) begin n_err++; $display("FAIL rdy_resume: got busy=%b want 01", rd_busy); end
    idle(); set_cm(0, 0, 0, 32'd77); set_issue(0, 2); set_rd(0, 0); set_rd(1, 0); tick();
    idle(); #1;
    n_vec++;
    if (rd_val !== '0 || rd_busy !== 2'b00 || rd_tag !== '0) begin
      n_err++; $display("FAIL x0_read: got val=%h busy=%b tag=%h want 0", rd_val, rd_busy, rd_tag);
    end
  endtask

  task automatic test_async_reset();
    idle(); set_issue(6, 9); tick();
    idle(); rdy_in = 1'b0; set_rd(0, 6); set_rd(1, 12);
    #2 rst_in = 1'b0; model_reset(); #1;
    n_vec++;
    if (rd_busy !== 2'b00 || rd_val !== '0 || rd_tag !== '0 || busy_cnt !== '0) begin
      n_err++; $display("FAIL async_reset: got busy=%b val=%h tag=%h cnt=%0d want all 0",
                        rd_busy, rd_val, rd_tag, busy_cnt);
    end
    #2 rst_in = 1'b1; idle();
    @(posedge clk_in); #1;
  endtask

  task automatic test_random();
    data_t    ev;
    logic     eb;
    rob_tag_t et;
    reg_idx_t r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      rdy_in = ($urandom_range(9) != 0);
      flush  = ($urandom_range(31) == 0);
      if ($urandom_range(9) < 6) set_issue(reg_idx_t'($urandom_range(7)), rob_tag_t'($urandom));
      for (int k = 0; k < CP; k++) begin
        if ($urandom_range(1) == 1) begin
          r = reg_idx_t'($urandom_range(7));
          set_cm(k, r, ($urandom_range(1) == 1) ? m_tag[r] : rob_tag_t'($urandom), data_t'($urandom));
        end
      end
      for (int p = 0; p < RP; p++)
        set_rd(p, ($urandom_range(3) == 0) ? reg_idx_t'($urandom) : reg_idx_t'($urandom_range(7)));
      #1;
      for (int p = 0; p < RP; p++) begin
        model_read(p, ev, eb, et);
        n_vec++;
        if (rd_val[p*DW +: DW] !== ev || rd_busy[p] !== eb || rd_tag[p*TW +: TW] !== et) begin
          n_err++;
          $display("FAIL rand_read c%0d p%0d x%0d: got %h/%b/%h want %h/%b/%h", cyc, p,
                   rd_idx[p*RW +: RW], rd_val[p*DW +: DW], rd_busy[p], rd_tag[p*TW +: TW], ev, eb, et);
        end
      end
      n_vec++;
      if (busy_cnt !== model_cnt()) begin
        n_err++; $display("FAIL rand_cnt c%0d: got %0d want %0d", cyc, busy_cnt, model_cnt());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stale_commit();
    test_multi_commit();
    test_flush();
    test_rdy_and_x0();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
